// File: rtl/bbfifo_16x8_ctrl_if.sv
// Handshake and memory-control bundle between a FIFO user and the
// 16x8 FIFO pointer/flag controller.
interface bbfifo_16x8_ctrl_if #(
  parameter int AW = 4
);
  logic          wr_en_i;
  logic          rd_en_i;
  logic          flush_i;
  logic          clr_err_i;
  logic          mem_wen_o;
  logic [AW-1:0] mem_waddr_o;
  logic [AW-1:0] mem_raddr_o;
  logic          wr_ack_o;
  logic          rd_ack_o;
  logic [AW:0]   count_o;
  logic          empty_o;
  logic          full_o;
  logic          half_full_o;
  logic          overflow_o;
  logic          underflow_o;

  // The FIFO user drives the requests and observes status.
  modport master (
    output wr_en_i, rd_en_i, flush_i, clr_err_i,
    input  mem_wen_o, mem_waddr_o, mem_raddr_o, wr_ack_o, rd_ack_o,
           count_o, empty_o, full_o, half_full_o, overflow_o, underflow_o
  );

  // The controller consumes the requests and produces status.
  modport slave (
    input  wr_en_i, rd_en_i, flush_i, clr_err_i,
    output mem_wen_o, mem_waddr_o, mem_raddr_o, wr_ack_o, rd_ack_o,
           count_o, empty_o, full_o, half_full_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/bbfifo_16x8_ctrl.sv
// Pointer and flag controller for a 16x8 show-ahead FIFO memory used for
// UART TX/RX buffering. Generates write enable and addresses for the
// memory, tracks occupancy and keeps sticky overflow/underflow flags.
module bbfifo_16x8_ctrl #(
  parameter int AW         = 4,
  parameter int HALF_LEVEL = 8
) (
  input logic                clk,
  input logic                rst_n,
  bbfifo_16x8_ctrl_if.slave  bus
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(1 << AW);
  localparam logic [AW:0] HALF_CNT  = (AW+1)'(HALF_LEVEL);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          rd_ack;
  logic          ovf_set;
  logic          udf_set;

  // Status decode from the registered count, then same-cycle acceptance;
  // flush suppresses every request and every error.
  always_comb begin
    full    = (count == DEPTH_CNT);
    empty   = (count == '0);
    wr_ack  = bus.wr_en_i & ~full  & ~bus.flush_i;
    rd_ack  = bus.rd_en_i & ~empty & ~bus.flush_i;
    ovf_set = bus.wr_en_i &  full  & ~bus.flush_i;
    udf_set = bus.rd_en_i &  empty & ~bus.flush_i;
  end

  // Pointer and occupancy registers; flush outranks push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ack) wptr <= wptr + 1'b1;
      if (rd_ack) rptr <= rptr + 1'b1;
      case ({wr_ack, rd_ack})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)            overflow  <= 1'b1;
      else if (bus.clr_err_i) overflow  <= 1'b0;
      if (udf_set)            underflow <= 1'b1;
      else if (bus.clr_err_i) underflow <= 1'b0;
    end
  end

  assign bus.mem_wen_o   = wr_ack;
  assign bus.mem_waddr_o = wptr;
  assign bus.mem_raddr_o = rptr;
  assign bus.wr_ack_o    = wr_ack;
  assign bus.rd_ack_o    = rd_ack;
  assign bus.count_o     = count;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.half_full_o = (count >= HALF_CNT);
  assign bus.overflow_o  = overflow;
  assign bus.underflow_o = underflow;

  // Occupancy must always equal the pointer distance; equal pointers mean
  // either empty or completely full.
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    (count == DEPTH_CNT) ? (wptr == rptr)
                         : ((count < DEPTH_CNT) && (count[AW-1:0] == AW'(wptr - rptr))));

endmodule
